// File: rtl/aes_decr_if.sv
// Handshake bundle between an AES-128 decryption core and its producer/consumer.
// master drives ciphertext/key and out_ready; slave is the core side.
interface aes_decr_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ip_data;
   logic [127:0] ip_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] decr_data_out;

   modport master (
      output in_valid, ip_data, ip_key, out_ready,
      input  in_ready, out_valid, decr_data_out
   );

   modport slave (
      input  in_valid, ip_data, ip_key, out_ready,
      output in_ready, out_valid, decr_data_out
   );
endinterface

// File: rtl/aes_decr.sv
// Iterative AES-128 inverse cipher, one round per clock, key expanded forward into an rk store.
// Optional key cache enabled by defining AES_DECR_KEY_CACHE_EN.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a ciphertext/key pair
// KEYEXP | writes rk[r] from rk[r-1], r = 1..10
// INIT   | state = ct ^ rk[10]
// ROUND  | one inverse round with rk[r], r = 9..1
// FINAL  | last inverse round with rk[0] into the output register
// DONE   | out_valid held until out_ready
module aes_decr #(
   parameter int DATA_WIDTH = 8
) (
   input  logic      clk,
   input  logic      rst,
   aes_decr_if.slave bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_KEYEXP = 3'd1;
   localparam logic [2:0] S_INIT   = 3'd2;
   localparam logic [2:0] S_ROUND  = 3'd3;
   localparam logic [2:0] S_FINAL  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] m);
      logic [7:0] b2, b4, b8;
      b2 = xt(b);
      b4 = xt(b2);
      b8 = xt(b4);
      return (m[0] ? b : 8'h00) ^ (m[1] ? b2 : 8'h00) ^ (m[2] ? b4 : 8'h00) ^ (m[3] ? b8 : 8'h00);
   endfunction

   // Row r of the column-major state rotates right by r columns.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-DATA_WIDTH*(4*c+r) -: DATA_WIDTH] = s[127-DATA_WIDTH*(4*((c-r+4)%4)+r) -: DATA_WIDTH];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         o[127-DATA_WIDTH*i -: DATA_WIDTH] = INV_SBOX[s[127-DATA_WIDTH*i -: DATA_WIDTH]];
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-DATA_WIDTH*(4*c)   -: DATA_WIDTH];
         a1 = s[127-DATA_WIDTH*(4*c+1) -: DATA_WIDTH];
         a2 = s[127-DATA_WIDTH*(4*c+2) -: DATA_WIDTH];
         a3 = s[127-DATA_WIDTH*(4*c+3) -: DATA_WIDTH];
         o[127-DATA_WIDTH*(4*c)   -: DATA_WIDTH] = gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9);
         o[127-DATA_WIDTH*(4*c+1) -: DATA_WIDTH] = gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd);
         o[127-DATA_WIDTH*(4*c+2) -: DATA_WIDTH] = gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb);
         o[127-DATA_WIDTH*(4*c+3) -: DATA_WIDTH] = gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he);
      end
      return o;
   endfunction

   function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = k;
      t  = {SBOX[w3[23:16]] ^ rc, SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   logic [2:0]   state_q, state_d;
   logic [3:0]   r_q, r_d;
   logic         out_valid_q, out_valid_d;
   logic [127:0] st_q;
   logic [127:0] dout_q;
   logic [127:0] rk_q [11];

   logic         accept;
   logic [127:0] rk_next, isr_isb, round_out, final_out;

   assign accept    = (state_q == S_IDLE) && bus.in_valid;
   assign rk_next   = expand_key(rk_q[r_q - 4'd1], rcon(r_q));
   assign isr_isb   = inv_sub_bytes(inv_shift_rows(st_q));
   assign round_out = inv_mix_cols(isr_isb ^ rk_q[r_q]);
   assign final_out = isr_isb ^ rk_q[0];

   assign bus.in_ready      = (state_q == S_IDLE);
   assign bus.out_valid     = out_valid_q;
   assign bus.decr_data_out = dout_q;

`ifdef AES_DECR_KEY_CACHE_EN
   logic         cache_vld_q;
   logic [127:0] cache_key_q;
   logic         cache_hit;

   // A hit is only trusted because every miss clears the flag before rewriting the rk store.
   assign cache_hit = cache_vld_q && (bus.ip_key == cache_key_q);
`endif

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
`ifdef AES_DECR_KEY_CACHE_EN
               if (cache_hit) begin
                  state_d = S_INIT;
               end else begin
                  state_d = S_KEYEXP;
                  r_d     = 4'd1;
               end
`else
               state_d = S_KEYEXP;
               r_d     = 4'd1;
`endif
            end
         end
         S_KEYEXP: begin
            if (r_q == 4'd10) state_d = S_INIT;
            else              r_d     = r_q + 4'd1;
         end
         S_INIT: begin
            state_d = S_ROUND;
            r_d     = 4'd9;
         end
         S_ROUND: begin
            r_d = r_q - 4'd1;
            if (r_q == 4'd1) state_d = S_FINAL;
         end
         S_FINAL: begin
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         r_q         <= 4'd0;
         out_valid_q <= 1'b0;
         st_q        <= '0;
         dout_q      <= '0;
         for (int i = 0; i < 11; i++) rk_q[i] <= '0;
`ifdef AES_DECR_KEY_CACHE_EN
         cache_vld_q <= 1'b0;
         cache_key_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         out_valid_q <= out_valid_d;
         if (accept) begin
            st_q     <= bus.ip_data;
            rk_q[0]  <= bus.ip_key;
         end
         if (state_q == S_KEYEXP) rk_q[r_q] <= rk_next;
         if (state_q == S_INIT)   st_q      <= st_q ^ rk_q[10];
         if (state_q == S_ROUND)  st_q      <= round_out;
         if (state_q == S_FINAL)  dout_q    <= final_out;
`ifdef AES_DECR_KEY_CACHE_EN
         if (accept && !cache_hit) begin
            cache_vld_q <= 1'b0;
            cache_key_q <= bus.ip_key;
         end
         if (state_q == S_KEYEXP && r_q == 4'd10) cache_vld_q <= 1'b1;
`endif
      end
   end
endmodule

// File: doc/aes_decr.md
# aes_decr

Iterative AES-128 decryption core: the inverse of `aes_encr`, turning a 128-bit ciphertext back into plaintext under a 128-bit cipher key. It expands the key forward into an internal round-key store, then runs the inverse cipher at one round per clock. A valid/ready handshake sits on both input and output. It is the receive-side partner of `aes_encr` in the AES128 datapath.

## Interface
- `DATA_WIDTH`, 8: byte width of state elements; only 8 is supported.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  ciphertext/key pair offered.
- `in_ready`  output  1  core idle and able to accept.
- `ip_data`  input  128  ciphertext; `[127:120]` is state byte 0, column-major (FIPS-197 order).
- `ip_key`  input  128  cipher key (the round-0 key, not the last round key), same byte order.
- `out_valid`  output  1  plaintext available.
- `out_ready`  input  1  downstream consumes plaintext.
- `decr_data_out`  output  128  plaintext, same byte order.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, capture `ip_data` and `ip_key` and write the key into round-key slot 0. Then go to KEYEXP.
  - KEYEXP: round counter `r` runs 1..10. Each cycle writes `rk[r]` = expand(`rk[r-1]`, Rcon[r]), with Rcon = 01,02,04,08,10,20,40,80,1b,36. After `r`=10, go to INIT.
  - INIT: state <= ct ^ `rk[10]`. Set `r`=9 and go to ROUND.
  - ROUND: state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), `rk[r]`)). Decrement `r`. After `r`=1, go to FINAL.
  - FINAL: `decr_data_out` <= InvSubBytes(InvShiftRows(state)) ^ `rk[0]`. Assert `out_valid`, go to DONE.
  - DONE: hold `decr_data_out` and `out_valid` until `out_valid && out_ready`. Then deassert `out_valid` and return to IDLE.
- Inverse S-box is a combinational 256-entry ROM. Each cycle uses 16 instances for the state path and 4 forward S-box instances for key expansion.
- InvMixColumns uses GF(2^8) multiply by 09/0b/0d/0e with polynomial 0x11b. All byte arithmetic is modulo that field; there is no carry out.
- Inputs are sampled only on the accept edge. Later changes to `ip_data`/`ip_key` have no effect.
- `in_valid` outside IDLE is ignored; the upstream must hold it until `in_ready`.
- `in_ready` is low from the accept edge until the edge that leaves DONE.

## Timing
- Reset (`rst`=0 at a rising edge): FSM goes to IDLE.
  - Outputs: `in_ready`=1, `out_valid`=0, `decr_data_out`=0.
  - `r`=0, round-key store cleared, key-cache valid flag cleared.
- Reset mid-operation aborts the block immediately. The in-flight block is discarded and no `out_valid` is produced.
- Latency with key expansion, counted from accept edge E0:
  - rk1..rk10 written at E1..E10.
  - INIT at E11.
  - Middle rounds at E12..E20.
  - FINAL at E21; `out_valid`=1 from E21.
- Throughput: with `out_ready` tied high, DONE lasts one cycle. The next accept is possible at E23, so there are 23 cycles per block.
- Back-pressure: `out_valid` stays high and `decr_data_out` stays stable for any number of cycles while `out_ready`=0.
- `out_ready` high when `out_valid`=0 has no effect.

## Configuration
- `AES_DECR_KEY_CACHE_EN` defined:
  - A 128-bit register holds the last fully expanded key, with a valid flag.
  - On accept, if the flag is set and `ip_key` equals the cached key, KEYEXP is skipped and the FSM enters INIT at E1. `out_valid` then rises at E11.
  - The flag is set at completion of KEYEXP. It is cleared by reset and when a new key's expansion starts.
- Not defined:
  - No cache register and no comparator.
  - Every block runs KEYEXP, so latency is always 21.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key `000102030405060708090a0b0c0d0e0f`, ct `69c4e0d86a7b0430d8cdb78070b4c55a`.
  - Response: `decr_data_out` = `00112233445566778899aabbccddeeff`, with `out_valid` exactly 21 cycles after accept.
- FIPS-197 B:
  - Stimulus: key `2b7e151628aed2a6abf7158809cf4f3c`, ct `3925841d02dc09fbdc118597196a0b32`.
  - Response: pt `3243f6a8885a308d313198a2e0370734`.
  - Also check `rk[10]` = `d014f9a8c9ee2589e13f0cc8b6630ca6` by probe.
- Loopback:
  - Stimulus: `aes_encr` output for data `AEFED67589AFEDFCAE657877FFEA8676`, key `FE657897FFEA567645AEDECD56891267`, fed into this core.
  - Response: original data recovered.
- Back-pressure:
  - Stimulus: hold `out_ready`=0 for 7 cycles after `out_valid`, and toggle `ip_data` and `in_valid` during that time.
  - Response: output stable, `in_ready`=0, no second accept. The FSM returns to IDLE one cycle after `out_ready`=1.
- Reset mid-run:
  - Stimulus: drop `rst` at E15 for 1 cycle.
  - Response: `in_ready`=1, `out_valid`=0, output 0. A following C.1 run still passes, with latency 21 even when `AES_DECR_KEY_CACHE_EN` is defined.
- Cache (`AES_DECR_KEY_CACHE_EN` defined):
  - Stimulus: two C.1 blocks back-to-back with the same key, then a third with the B key.
  - Response: latencies 21, 11, 21, and all plaintexts correct.
